// File: rtl/fetch_decode_unit.sv
// Fetch/decode front end of the 4-bit nanoprocessor: sequences the program counter,
// registers each fetched instruction and decodes it into datapath controls.
module fetch_decode_unit (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] pm_data,
  input  logic       r_eq_0,
  output logic [7:0] pm_addr,
  output logic [7:0] pc,
  output logic [7:0] ir,
  output logic [3:0] nibble_ir,
  output logic [3:0] source_sel,
  output logic [9:0] reg_en,
  output logic       i_sel,
  output logic       x_sel,
  output logic       y_sel,
  output logic       sync_reset
);

  typedef enum logic [3:0] {
    SRC_X0   = 4'd0,
    SRC_X1   = 4'd1,
    SRC_Y0   = 4'd2,
    SRC_Y1   = 4'd3,
    SRC_R    = 4'd4,
    SRC_M    = 4'd5,
    SRC_I    = 4'd6,
    SRC_DM   = 4'd7,
    SRC_IMM  = 4'd8,
    SRC_PINS = 4'd9,
    SRC_IDLE = 4'd15
  } src_e;

  typedef enum logic [1:0] {
    OP_LOAD,
    OP_MOVE,
    OP_ALU,
    OP_JUMP
  } op_e;

  localparam logic [2:0] DST_OREG = 3'd4;
  localparam logic [2:0] DST_I    = 3'd6;
  localparam logic [2:0] DST_DM   = 3'd7;

  // Destination code to write-enable bit; code 100 addresses o_reg at bit 8.
  function automatic logic [9:0] dst_onehot(input logic [2:0] d);
    if (d == DST_OREG) return 10'h100;
    return 10'd1 << d;
  endfunction

  function automatic op_e classify(input logic [7:0] w);
    if (!w[7])      return OP_LOAD;
    else if (!w[6]) return OP_MOVE;
    else if (!w[5]) return OP_ALU;
    return OP_JUMP;
  endfunction

  // Reset synchronizer: ones shift in after release, so sync_reset spans two edges.
  logic [1:0] rst_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign sync_reset = ~rst_sync[1];

  // Sequencer
  logic ir_valid;
  logic is_jmp;
  logic is_jnz;
  logic jump_taken;

  assign is_jmp     = (ir[7:4] == 4'hE);
  assign is_jnz     = (ir[7:4] == 4'hF);
  assign jump_taken = ir_valid & (is_jmp | (is_jnz & ~r_eq_0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= 8'h00;
      ir       <= 8'h00;
      ir_valid <= 1'b0;
    end else if (sync_reset) begin
      pc       <= 8'h00;
      ir       <= 8'h00;
      ir_valid <= 1'b0;
    end else if (jump_taken) begin
      // The word already fetched behind the jump is loaded but never decoded.
      pc       <= {4'h0, ir[3:0]};
      ir       <= pm_data;
      ir_valid <= 1'b0;
    end else begin
      pc       <= pc + 8'd1;
      ir       <= pm_data;
      ir_valid <= 1'b1;
    end
  end

  assign pm_addr   = pc;
  assign nibble_ir = ir[3:0];

  // Decode
  op_e        op;
  src_e       src;
  logic [2:0] dst;
  logic [2:0] sss;
  logic       writes_dst;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    op         = classify(ir);
    src        = SRC_IDLE;
    dst        = 3'd0;
    sss        = 3'd0;
    writes_dst = 1'b0;
    reg_en     = '0;
    i_sel      = 1'b0;
    x_sel      = 1'b0;
    y_sel      = 1'b0;

    if (ir_valid) begin
      unique case (op)
        OP_LOAD: begin
          dst        = ir[6:4];
          src        = SRC_IMM;
          writes_dst = 1'b1;
        end
        OP_MOVE: begin
          dst        = ir[5:3];
          sss        = ir[2:0];
          writes_dst = 1'b1;
          // A self-move (other than r->o_reg) reads the external input pins instead.
          if (sss == dst && dst != DST_OREG) src = SRC_PINS;
          else                               src = src_e'({1'b0, sss});
        end
        OP_ALU: begin
          x_sel     = ir[4];
          y_sel     = ir[3];
          reg_en[4] = 1'b1;
        end
        OP_JUMP: begin
        end
      endcase
    end

    if (writes_dst) begin
      reg_en = reg_en | dst_onehot(dst);
      // Touching dm post-increments i by m, unless i itself is being loaded.
      if (dst == DST_I) begin
        i_sel = 1'b0;
      end else if (src == SRC_DM || dst == DST_DM) begin
        reg_en[6] = 1'b1;
        i_sel     = 1'b1;
      end
    end

    source_sel = src;
  end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Self-checking bench for fetch_decode_unit: a program-flow/decode reference model
// checked every cycle, plus directed literal checks from the block's test plan.
module tb_fetch_decode_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] pm_data;
  logic       r_eq_0;
  logic [7:0] pm_addr, pc, ir;
  logic [3:0] nibble_ir, source_sel;
  logic [9:0] reg_en;
  logic       i_sel, x_sel, y_sel, sync_reset;

  logic [7:0] rom [256];

  always #5 clk = ~clk;

  assign pm_data = rom[pm_addr];

  fetch_decode_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pm_data    (pm_data),
    .r_eq_0     (r_eq_0),
    .pm_addr    (pm_addr),
    .pc         (pc),
    .ir         (ir),
    .nibble_ir  (nibble_ir),
    .source_sel (source_sel),
    .reg_en     (reg_en),
    .i_sel      (i_sel),
    .x_sel      (x_sel),
    .y_sel      (y_sel),
    .sync_reset (sync_reset)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected decode of one instruction word, written from the instruction-set rules.
  typedef struct packed {
    logic [3:0] src;
    logic [9:0] en;
    logic       isel;
    logic       xs;
    logic       ys;
  } dec_t;

  function automatic dec_t model_dec(input logic [7:0] w, input bit v);
    dec_t   d;
    int     dst_code;
    int     src_code;
    bit     wr;
    d        = '{src: 4'd15, en: 10'd0, isel: 1'b0, xs: 1'b0, ys: 1'b0};
    wr       = 0;
    dst_code = 0;
    src_code = 15;
    if (v) begin
      if (w < 8'h80) begin
        dst_code = (w >> 4) & 7;
        src_code = 8;
        wr       = 1;
      end else if (w < 8'hC0) begin
        dst_code = (w >> 3) & 7;
        src_code = w & 7;
        if (src_code == dst_code && dst_code != 4) src_code = 9;
        wr       = 1;
      end else if (w < 8'hE0) begin
        d.xs = w[4];
        d.ys = w[3];
        d.en = 10'h010;
      end
    end
    if (wr) begin
      d.en = (dst_code == 4) ? 10'h100 : 10'(1 << dst_code);
      if (dst_code != 6 && (src_code == 7 || dst_code == 7)) begin
        d.en   = d.en | 10'h040;
        d.isel = 1'b1;
      end
    end
    d.src = 4'(src_code);
    return d;
  endfunction

  // Model state: address of next fetch, word in the instruction register, whether
  // that word executes, and how many reset-synchronizer edges remain.
  logic [7:0] m_pc;
  logic [7:0] m_ir;
  bit         m_valid;
  bit         m_ir_known;
  int         m_cnt;

  always @(negedge clk) begin
    dec_t       e;
    bit         taken;
    logic [7:0] target;
    if (!reset_n) begin
      m_pc       = 8'h00;
      m_ir       = 8'h00;
      m_valid    = 0;
      m_ir_known = 1;
      m_cnt      = 2;
    end
    e = model_dec(m_ir, m_valid);
    check("pc",         pc,         m_pc);
    check("pm_addr",    pm_addr,    m_pc);
    check("sync_reset", sync_reset, (m_cnt > 0) ? 1 : 0);
    check("source_sel", source_sel, e.src);
    check("reg_en",     reg_en,     e.en);
    check("i_sel",      i_sel,      e.isel);
    check("x_sel",      x_sel,      e.xs);
    check("y_sel",      y_sel,      e.ys);
    if (m_ir_known) begin
      check("ir",        ir,        m_ir);
      check("nibble_ir", nibble_ir, m_ir[3:0]);
    end
    if (reset_n) begin
      if (m_cnt > 0) begin
        m_cnt--;
        m_pc       = 8'h00;
        m_valid    = 0;
        m_ir_known = 0;
      end else begin
        taken  = m_valid && (m_ir[7:4] == 4'hE || (m_ir[7:4] == 4'hF && !r_eq_0));
        target = {4'h0, m_ir[3:0]};
        m_ir       = rom[m_pc];
        m_ir_known = 1;
        if (taken) begin
          m_pc    = target;
          m_valid = 0;
        end else begin
          m_pc    = m_pc + 8'd1;
          m_valid = 1;
        end
      end
    end
  end

  task automatic assert_reset();
    @(posedge clk);
    #2 reset_n = 1'b0;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  // Land 3 time units after the n-th rising edge from now.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic load_decode_program();
    logic [7:0] prog [10];
    prog = '{8'h37, 8'h8A, 8'h9B, 8'hA4, 8'h87, 8'hB7, 8'h7C, 8'hDA, 8'hF5, 8'h37};
    for (int i = 0; i < 256; i++) rom[i] = 8'h37;
    for (int i = 0; i < 10; i++) rom[i] = prog[i];
  endtask

  initial begin
    bit found;
    reset_n = 1'b0;
    r_eq_0  = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;

    // Reset release, straight-line decode and a not-taken jnz.
    load_decode_program();
    #1;
    check("rst_pc",     pc,         8'h00);
    check("rst_sync",   sync_reset, 1'b1);
    check("rst_reg_en", reg_en,     10'h000);
    release_reset();
    wait_edges(1);
    check("rel1_sync",   sync_reset, 1'b1);
    check("rel1_pc",     pc,         8'h00);
    check("rel1_reg_en", reg_en,     10'h000);
    wait_edges(1);
    check("rel2_sync",   sync_reset, 1'b0);
    check("rel2_pc",     pc,         8'h00);
    check("rel2_reg_en", reg_en,     10'h000);
    wait_edges(1);
    check("ld_pc",     pc,         8'h01);
    check("ld_src",    source_sel, 4'd8);
    check("ld_en",     reg_en,     10'h008);
    check("ld_nib",    nibble_ir,  4'd7);
    wait_edges(1);
    check("mv_src",    source_sel, 4'd2);
    check("mv_en",     reg_en,     10'h002);
    wait_edges(1);
    check("pins_src",  source_sel, 4'd9);
    wait_edges(1);
    check("oreg_src",  source_sel, 4'd4);
    check("oreg_en",   reg_en,     10'h100);
    wait_edges(1);
    check("dmrd_src",  source_sel, 4'd7);
    check("dmrd_en",   reg_en,     10'h041);
    check("dmrd_isel", i_sel,      1'b1);
    wait_edges(1);
    check("idm_en",    reg_en,     10'h040);
    check("idm_isel",  i_sel,      1'b0);
    wait_edges(1);
    check("dmwr_en",   reg_en,     10'h0C0);
    check("dmwr_isel", i_sel,      1'b1);
    wait_edges(1);
    check("alu_x",     x_sel,      1'b1);
    check("alu_y",     y_sel,      1'b1);
    check("alu_en",    reg_en,     10'h010);
    check("alu_src",   source_sel, 4'd15);
    wait_edges(1);
    check("jnz_ir",    ir,         8'hF5);
    check("jnz_pc",    pc,         8'h09);
    wait_edges(1);
    check("jnznt_pc",  pc,         8'h0A);
    check("jnznt_src", source_sel, 4'd8);

    // Same program with the zero flag clear: jnz at 0x08 is taken to 0x05.
    assert_reset();
    r_eq_0 = 1'b0;
    release_reset();
    wait_edges(11);
    check("jnzt_ir",   ir,         8'hF5);
    wait_edges(1);
    check("jnzt_pc",   pc,         8'h05);
    check("jnzt_en",   reg_en,     10'h000);
    check("jnzt_src",  source_sel, 4'd15);
    wait_edges(1);
    check("jnzt_pc2",  pc,         8'h06);
    check("jnzt_ir2",  ir,         8'hB7);
    check("jnzt_en2",  reg_en,     10'h040);

    // Unconditional jump at 0x20 with a jump sitting in its squashed slot.
    assert_reset();
    r_eq_0 = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 8'h37;
    rom[8'h05] = 8'h8A;
    rom[8'h20] = 8'hE5;
    rom[8'h21] = 8'hE9;
    release_reset();
    wait_edges(35);
    check("jmp_ir",    ir,         8'hE5);
    check("jmp_pc",    pc,         8'h21);
    wait_edges(1);
    check("bub_pc",    pc,         8'h05);
    check("bub_en",    reg_en,     10'h000);
    check("bub_src",   source_sel, 4'd15);
    wait_edges(1);
    check("tgt_pc",    pc,         8'h06);
    check("tgt_ir",    ir,         8'h8A);
    check("tgt_src",   source_sel, 4'd2);
    wait_edges(28);
    check("bub2_pc",   pc,         8'h05);
    check("bub2_en",   reg_en,     10'h000);
    reset_n = 1'b0;
    #1;
    check("async_pc",   pc,         8'h00);
    check("async_sync", sync_reset, 1'b1);
    check("async_en",   reg_en,     10'h000);

    // Sequential run across the top of the address space.
    for (int i = 0; i < 256; i++) rom[i] = 8'h37;
    release_reset();
    found = 0;
    for (int n = 0; n < 300 && !found; n++) begin
      wait_edges(1);
      if (pc == 8'hFF) found = 1;
    end
    check("wrap_reached", found, 1);
    wait_edges(1);
    check("wrap_pc", pc, 8'h00);

    // Random programs with a random zero flag, restarted from reset several times.
    for (int round = 0; round < 4; round++) begin
      assert_reset();
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      release_reset();
      for (int n = 0; n < 1500; n++) begin
        @(posedge clk);
        #2 r_eq_0 = 1'($urandom_range(0, 1));
      end
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_decode_unit.md
# fetch_decode_unit

Program-sequencing and instruction-decode front end of the 4-bit nanoprocessor. It drives the program-memory address and registers each fetched 8-bit instruction. It decodes that instruction into the datapath controls the computational unit consumes: `source_sel`, `reg_en`, `i_sel`, `x_sel`, `y_sel` and `nibble_ir`. It also resolves unconditional and zero-flag-conditional jumps and generates the datapath's `sync_reset`.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- pm_data  in  8  program-memory word at `pm_addr` (combinational ROM)
- r_eq_0  in  1  zero flag from the computational unit
- pm_addr  out  8  fetch address, equal to `pc`
- pc  out  8  program counter
- ir  out  8  instruction register
- nibble_ir  out  4  `ir[3:0]`
- source_sel  out  4  data-bus source: 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 dm, 8 immediate, 9 i_pins, 15 idle
- reg_en  out  10  write enables: 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 dm, 8 o_reg, 9 always 0
- i_sel  out  1  1 = i <= i+m, 0 = i <= data_bus
- x_sel, y_sel  out  1  ALU operand selects
- sync_reset  out  1  synchronous reset for the datapath

## Operation
- Instruction valid: decode is gated by `ir_valid`. When `ir_valid` = 0, outputs are `reg_en` = 0, `source_sel` = 15, `i_sel` = `x_sel` = `y_sel` = 0.
- Load, `0ddd_kkkk`: `source_sel` = 8 and `reg_en[dst]` = 1, with dst encoding 000 x0, 001 x1, 010 y0, 011 y1, 100 o_reg (bit 8), 101 m, 110 i, 111 dm.
- Move, `10dd_dsss`:
  - dst uses the load encoding.
  - src: 000–011 x0–y1, 100 r, 101 m, 110 i, 111 dm.
  - If sss == ddd and ddd ≠ 100, the source is i_pins (`source_sel` = 9).
  - Move with ddd = sss = 100 is r→o_reg.
- dm auto-increment:
  - If the instruction reads dm (`source_sel` = 7) or writes dm (dst 111), and dst ≠ 110, then `reg_en[6]` = 1 and `i_sel` = 1.
  - If dst = 110, `i_sel` = 0 (load of i wins).
- ALU, `110x_yfff`: `x_sel` = `ir[4]`, `y_sel` = `ir[3]`, `reg_en[4]` = 1, `source_sel` = 15. The function is `ir[2:0]`, taken via `nibble_ir`.
- Jumps:
  - `1110_aaaa` is an unconditional jmp.
  - `1111_aaaa` is jnz, taken iff `r_eq_0` = 0.
  - Target is `{4'h0, aaaa}`.
  - Jumps assert no `reg_en` bit.
- Sequencer, on each clock edge when `sync_reset` = 0:
  - If the current ir is a valid taken jump: `pc` <= target and `ir_valid` <= 0 (squash the in-flight word).
  - Otherwise: `pc` <= `pc`+1, `ir` <= `pm_data`, `ir_valid` <= 1.
  - `ir` still loads `pm_data` on a squash; only `ir_valid` clears.
- `pc` wraps from 0xFF to 0x00.
- Reset synchronizer: a 2-flop chain. `sync_reset` is 1 asynchronously while `reset_n` = 0, and stays 1 for exactly 2 rising edges after `reset_n` rises. While `sync_reset` = 1, `pc` is held at 0 and `ir_valid` at 0.

## Timing
- Reset values (`reset_n` = 0): `pc` = 0, `ir` = 0x00, `ir_valid` = 0, `sync_reset` = 1; all decode outputs at their idle values.
- Fetch/execute:
  - Cycle n: `pm_addr` = A.
  - Edge n: `ir` = word(A).
  - Cycle n+1: controls for A are valid; the datapath commits at edge n+1.
  - Throughput is 1 instruction per cycle.
- Taken jump at A: costs one bubble cycle (`ir_valid` = 0); the first target instruction is decoded 2 cycles after the jump's decode cycle.
- Not-taken jnz costs no bubble.
- Flag timing: `r_eq_0` is sampled during the jnz decode cycle. An ALU op in the immediately preceding instruction has already updated the flag, so there is no hazard.
- Back-to-back jumps: the squashed word is never decoded, even if it is itself a jump.
- `reset_n` asserted mid-operation: all state goes to reset values immediately, without waiting for a clock edge. Any in-flight jump is discarded.
- All outputs are glitch-free functions of registered state plus `r_eq_0` (only the jnz taken decision depends on it).

## Test plan
- Reset release: drop then raise `reset_n` → `sync_reset` = 1 for 2 edges, then `pm_addr` sequences 0,1,2; first decode in cycle 3 after release; `reg_en` = 0 before that.
- Load/move decode:
  - `0x37` → `source_sel` = 8, `reg_en` = 0x008, `nibble_ir` = 7.
  - `0x8A` (x1←y0) → `source_sel` = 2, `reg_en` = 0x002.
  - `0x9B` (y1←y1) → `source_sel` = 9 (i_pins).
  - `0xA4` (o_reg←r) → `source_sel` = 4, `reg_en` = 0x100.
- dm increment:
  - `0x87` (x0←dm) → `source_sel` = 7, `reg_en` = 0x041, `i_sel` = 1.
  - `0xB7` (i←dm) → `reg_en` = 0x040, `i_sel` = 0.
  - `0x7C` (dm←imm) → `reg_en` = 0x0C0, `i_sel` = 1.
- ALU: `0xDA` → `x_sel` = 1, `y_sel` = 1, `reg_en` = 0x010, `source_sel` = 15.
- Jumps:
  - `0xE5` at address 0x20 → next decoded address is 0x05; one bubble with `reg_en` = 0; word at 0x21 is never executed.
  - `0xF5` with `r_eq_0` = 1 → no bubble, falls through.
  - `0xF5` with `r_eq_0` = 0 → taken.
- Wrap and async reset: run `pc` to 0xFF → next is 0x00. Assert `reset_n` mid-jump-bubble → `pc` = 0 with no clock edge, `sync_reset` = 1.
